// File: rtl/ssm_tile_feeder_pkg.sv
// Shared constants, address-width helper and FSM state type for the SSM tile feeder.
// Module parameters default to these values; the address widths here describe the default build.
package ssm_pkg;

    localparam int DW      = 16;
    localparam int H       = 24;
    localparam int P       = 64;
    localparam int N_TOTAL = 128;
    localparam int N_TILE  = 16;
    localparam int TILES   = N_TOTAL / N_TILE;

    // Bits needed to hold indices 0..n-1, never less than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SC_AW = addr_w(H);
    localparam int X_AW  = addr_w(H * P);
    localparam int BC_AW = addr_w(TILES);
    localparam int HP_AW = addr_w(H * P * TILES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        DONE
    } state_e;

endpackage

// File: rtl/ssm_tile_feeder_if.sv
// Tile stream from the feeder to SSMBLOCK_TOP: valid/ready handshake plus scalars, payload and tag.
interface ssm_tile_feeder_if #(
    parameter int DW     = ssm_pkg::DW,
    parameter int N_TILE = ssm_pkg::N_TILE,
    parameter int HPW    = ssm_pkg::X_AW
);

    logic                   tile_valid_o;
    logic                   tile_ready_i;
    logic [DW-1:0]          dt_o;
    logic [DW-1:0]          dt_bias_o;
    logic [DW-1:0]          A_o;
    logic [DW-1:0]          D_o;
    logic [DW-1:0]          x_o;
    logic [N_TILE*DW-1:0]   B_tile_o;
    logic [N_TILE*DW-1:0]   C_tile_o;
    logic [N_TILE*DW-1:0]   hprev_tile_o;
    logic                   tile_last_o;
    logic [HPW-1:0]         hp_idx_o;

    modport master (
        output tile_valid_o, dt_o, dt_bias_o, A_o, D_o, x_o,
               B_tile_o, C_tile_o, hprev_tile_o, tile_last_o, hp_idx_o,
        input  tile_ready_i
    );

    modport slave (
        input  tile_valid_o, dt_o, dt_bias_o, A_o, D_o, x_o,
               B_tile_o, C_tile_o, hprev_tile_o, tile_last_o, hp_idx_o,
        output tile_ready_i
    );

endinterface

// File: rtl/ssm_tile_feeder_scan_cnt.sv
// Nested h/p/t scan counter (t fastest, h slowest) with flat index h*P+p and an end-of-scan flag.
module ssm_scan_cnt
    import ssm_pkg::*;
#(
    parameter int  H     = 2,
    parameter int  P     = 2,
    parameter int  TILES = 2,
    localparam int HW    = addr_w(H),
    localparam int PW    = addr_w(P),
    localparam int TW    = addr_w(TILES),
    localparam int HPW   = addr_w(H * P)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           adv_i,
    output logic [HW-1:0]  h_o,
    output logic [PW-1:0]  p_o,
    output logic [TW-1:0]  t_o,
    output logic [HPW-1:0] hp_o,
    output logic           last_o
);

    logic [HW-1:0] h_q, h_d;
    logic [PW-1:0] p_q, p_d;
    logic [TW-1:0] t_q, t_d;
    logic          t_wrap, p_wrap, h_wrap;

    assign t_wrap = (t_q == TW'(TILES - 1));
    assign p_wrap = (p_q == PW'(P - 1));
    assign h_wrap = (h_q == HW'(H - 1));

    always_comb begin
        h_d = h_q;
        p_d = p_q;
        t_d = t_q;
        if (clr_i) begin
            h_d = '0;
            p_d = '0;
            t_d = '0;
        end else if (adv_i) begin
            if (!t_wrap) begin
                t_d = t_q + TW'(1);
            end else begin
                t_d = '0;
                if (!p_wrap) begin
                    p_d = p_q + PW'(1);
                end else begin
                    p_d = '0;
                    h_d = h_wrap ? '0 : h_q + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            p_q <= '0;
            t_q <= '0;
        end else begin
            h_q <= h_d;
            p_q <= p_d;
            t_q <= t_d;
        end
    end

    assign h_o    = h_q;
    assign p_o    = p_q;
    assign t_o    = t_q;
    assign hp_o   = HPW'(32'(h_q) * 32'(P) + 32'(p_q));
    assign last_o = t_wrap & p_wrap & h_wrap;

endmodule

// File: rtl/ssm_tile_feeder.sv
// Scans every (h,p) pair and its tiles, reads scalars and tile payloads from 1-cycle-latency
// buffers, and presents one registered tile per valid/ready handshake (3 cycles per tile).
module ssm_tile_feeder
    import ssm_pkg::*;
#(
    parameter int  DW      = ssm_pkg::DW,
    parameter int  H       = ssm_pkg::H,
    parameter int  P       = ssm_pkg::P,
    parameter int  N_TOTAL = ssm_pkg::N_TOTAL,
    parameter int  N_TILE  = ssm_pkg::N_TILE,
    localparam int TILES   = N_TOTAL / N_TILE,
    localparam int SC_AW   = addr_w(H),
    localparam int P_AW    = addr_w(P),
    localparam int X_AW    = addr_w(H * P),
    localparam int BC_AW   = addr_w(TILES),
    localparam int HP_AW   = addr_w(H * P * TILES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [SC_AW-1:0]     sc_addr_o,
    output logic [X_AW-1:0]      x_addr_o,
    output logic [BC_AW-1:0]     bc_addr_o,
    output logic [HP_AW-1:0]     hp_addr_o,
    input  logic [4*DW-1:0]      sc_rdata_i,
    input  logic [DW-1:0]        x_rdata_i,
    input  logic [N_TILE*DW-1:0] B_rdata_i,
    input  logic [N_TILE*DW-1:0] C_rdata_i,
    input  logic [N_TILE*DW-1:0] hprev_rdata_i,
    ssm_tile_feeder_if.master    tile
);

    state_e state_q, state_d;

    logic [SC_AW-1:0] h;
    logic [P_AW-1:0]  p;
    logic [BC_AW-1:0] t;
    logic [X_AW-1:0]  hp;
    logic             scan_last;
    logic             cap_en, adv, clr, valid;

    logic [DW-1:0]        dt_q, dt_bias_q, a_q, d_q, x_q;
    logic [N_TILE*DW-1:0] b_q, c_q, hprev_q;
    logic                 last_q;
    logic [X_AW-1:0]      hp_idx_q;

    ssm_scan_cnt #(
        .H     (H),
        .P     (P),
        .TILES (TILES)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .adv_i  (adv),
        .h_o    (h),
        .p_o    (p),
        .t_o    (t),
        .hp_o   (hp),
        .last_o (scan_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND:    if (tile.tile_ready_i) state_d = scan_last ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        cap_en  = 1'b0;
        valid   = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE:    ;
            FETCH: begin
                busy_o  = 1'b1;
                rd_en_o = 1'b1;
            end
            CAPTURE: begin
                busy_o = 1'b1;
                cap_en = 1'b1;
            end
            SEND: begin
                busy_o = 1'b1;
                valid  = 1'b1;
                adv    = tile.tile_ready_i;
            end
            DONE: begin
                done_o = 1'b1;
                clr    = 1'b1;
            end
            default: ;
        endcase
    end

    // Addresses follow the counters, which only move on a handshake, so they are stable in FETCH.
    assign sc_addr_o = h;
    assign x_addr_o  = hp;
    assign bc_addr_o = t;
    assign hp_addr_o = HP_AW'(32'(hp) * 32'(TILES) + 32'(t));

    always_ff @(posedge clk) begin
        if (rst) begin
            dt_q      <= '0;
            dt_bias_q <= '0;
            a_q       <= '0;
            d_q       <= '0;
            x_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            hprev_q   <= '0;
            last_q    <= 1'b0;
            hp_idx_q  <= '0;
        end else if (cap_en) begin
            {d_q, a_q, dt_bias_q, dt_q} <= sc_rdata_i;
            x_q      <= x_rdata_i;
            b_q      <= B_rdata_i;
            c_q      <= C_rdata_i;
            hprev_q  <= hprev_rdata_i;
            last_q   <= (t == BC_AW'(TILES - 1));
            hp_idx_q <= hp;
        end
    end

    assign tile.tile_valid_o = valid;
    assign tile.dt_o         = dt_q;
    assign tile.dt_bias_o    = dt_bias_q;
    assign tile.A_o          = a_q;
    assign tile.D_o          = d_q;
    assign tile.x_o          = x_q;
    assign tile.B_tile_o     = b_q;
    assign tile.C_tile_o     = c_q;
    assign tile.hprev_tile_o = hprev_q;
    assign tile.tile_last_o  = last_q;
    assign tile.hp_idx_o     = hp_idx_q;

endmodule
